// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data arbiter on the common memory port.
package mem_arbiter_pkg;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_HELD = 1'b1
   } fetch_state_t;

   // Size codes as they appear in funct3[1:0] of loads/stores.
   localparam logic [2:0] BYTE = 3'b000;
   localparam logic [2:0] HALF = 3'b001;
   localparam logic [2:0] WORD = 3'b010;

   localparam logic [2:0] FETCH_FUNCT3 = WORD;

endpackage

// File: rtl/addr_check.sv
// Combinational word-index extraction plus alignment and range check for a data access.
module addr_check
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_AW = 6
)(
   input  logic [31:0]        addr,
   input  logic [1:0]         size,
   output logic [WORD_AW-1:0] word,
   output logic               misaligned,
   output logic               out_of_range
);

   assign word         = addr[WORD_AW+1:2];
   assign out_of_range = |addr[31:WORD_AW+2];

   always_comb begin
      misaligned = 1'b0;
      case (size)
         BYTE[1:0]: misaligned = 1'b0;
         HALF[1:0]: misaligned = addr[0];
         WORD[1:0]: misaligned = |addr[1:0];
         default:   misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one combinational-read memory port between instruction fetch and MEM-stage
// data accesses; data always wins, and a held fetch word frees the port during pipeline stalls.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_AW = 6,
   parameter int unsigned CNT_W   = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   input  logic               if_hold,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   input  logic               dm_read,
   input  logic               dm_write,
   input  logic [2:0]         dm_funct3,
   input  logic [31:0]        dm_addr,
   input  logic [31:0]        dm_wdata,
   output logic [31:0]        dm_rdata,
   output logic               dm_fault,
   output logic               stall_if,
   output logic               mem_read,
   output logic               mem_write,
   output logic [2:0]         mem_funct3,
   output logic [WORD_AW-1:0] mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata,
   output logic [CNT_W-1:0]   conflict_cnt
);

   fetch_state_t       state;
   logic [31:0]        hold_word;
   logic [31:0]        hold_addr;
   logic [WORD_AW-1:0] last_addr;

   logic [WORD_AW-1:0] dm_word;
   logic [WORD_AW-1:0] if_word;
   logic               dm_misaligned;
   logic               dm_oor;
   logic               dm_req;
   logic               fault;
   logic               fetch_grant;
   logic               held_match;
   logic               coherence_hit;

   addr_check #(.WORD_AW(WORD_AW)) u_dm_check (
      .addr         (dm_addr),
      .size         (dm_funct3[1:0]),
      .word         (dm_word),
      .misaligned   (dm_misaligned),
      .out_of_range (dm_oor)
   );

   assign if_word = if_addr[WORD_AW+1:2];
   assign dm_req  = dm_read | dm_write;
   // A simultaneous load+store is treated as a fault: the store wins the port but is suppressed.
   assign fault   = dm_req & (dm_misaligned | dm_oor | (dm_read & dm_write));

   assign fetch_grant   = ~rst & ~dm_req & if_req & (state == FETCH_IDLE);
   assign held_match    = (state == FETCH_HELD) & (if_addr == hold_addr);
   assign coherence_hit = (state == FETCH_HELD) & mem_write & (dm_word == hold_addr[WORD_AW+1:2]);

   assign mem_write  = ~rst & dm_write & ~fault;
   assign mem_read   = ~rst & ((dm_read & ~fault) | fetch_grant);
   assign mem_funct3 = dm_req ? dm_funct3 : FETCH_FUNCT3;
   assign mem_wdata  = dm_wdata;
   assign mem_addr   = dm_req ? dm_word : (fetch_grant ? if_word : last_addr);

   assign dm_rdata = mem_rdata;
   assign dm_fault = ~rst & fault;
   assign stall_if = ~rst & dm_req & if_req & (state == FETCH_IDLE);

   // A held word is only presented while the fetch address still matches and no store is overwriting it.
   assign if_valid = fetch_grant | (~rst & held_match & ~coherence_hit);
   assign if_instr = (state == FETCH_HELD) ? hold_word : mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH_IDLE;
         hold_word    <= '0;
         hold_addr    <= '0;
         last_addr    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (dm_req | fetch_grant) begin
            last_addr <= mem_addr;
         end
         if (stall_if && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
         case (state)
            FETCH_IDLE: begin
               if (fetch_grant && if_hold) begin
                  hold_word <= mem_rdata;
                  hold_addr <= if_addr;
                  state     <= FETCH_HELD;
               end
            end
            FETCH_HELD: begin
               if (!if_hold || (if_addr != hold_addr) || coherence_hit) begin
                  state <= FETCH_IDLE;
               end
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end

endmodule
